// File: rtl/demux_stream_pkg.sv
// demux_stream_pkg
//   Shared definitions for the demux_stream slice.
//   - slot_state_e : per-channel slot state (SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1)
//   - STATS_W      : width of the optional handshake/error counters
//   - addr_w_f     : address width needed to index NCH channels
package demux_stream_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam int STATS_W = 16;

  // A 2-channel demux still needs one address bit, so the width never drops to 0.
  function automatic int addr_w_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot
//   One-entry output register for a single demux channel: a WIDTH-bit data
//   register plus a valid state (EMPTY/FULL).
//   Ports:
//     clk      in   rising-edge clock
//     rst      in   asynchronous active-high reset (clears state and data)
//     i_load   in   write the slot with i_data this cycle
//     i_drain  in   consumer takes the held beat this cycle
//     i_data   in   [WIDTH] beat to store
//     o_valid  out  slot holds a beat
//     o_data   out  [WIDTH] held beat (keeps last value while EMPTY)
module demux_slot
  import demux_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_drain,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  slot_state_e      r_state;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else begin
      case (r_state)
        SLOT_EMPTY: begin
          if (i_load) begin
            r_state <= SLOT_FULL;
            r_data  <= i_data;
          end
        end
        SLOT_FULL: begin
          // A load while FULL only happens when the consumer drains in the
          // same cycle, so the slot is refilled and stays FULL.
          if (i_load) begin
            r_data <= i_data;
          end else if (i_drain) begin
            r_state <= SLOT_EMPTY;
          end
        end
        default: r_state <= SLOT_EMPTY;
      endcase
    end
  end

  assign o_valid = (r_state == SLOT_FULL);
  assign o_data  = r_data;

endmodule

// File: rtl/demux_stream.sv
// demux_stream
//   Registered 1-to-NCH stream demultiplexer with valid/ready on the input
//   and on every output channel. Each channel has its own one-entry slot, so
//   a stalled consumer only blocks beats addressed to it.
//   Optional feature macro: DEMUX_STREAM_STATS_EN (adds ch_count/err_count).
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-high reset
//     in_data    in   [WIDTH] payload
//     in_addr    in   [ADDR_W] destination channel index
//     in_valid   in   producer has a beat
//     in_ready   out  beat accepted when in_valid && in_ready (combinational)
//     out_data   out  [NCH*WIDTH] channel k at [k*WIDTH +: WIDTH]
//     out_valid  out  [NCH] channel k holds a beat
//     out_ready  in   [NCH] consumer k takes its beat
//     addr_err   out  one-cycle pulse after an accepted out-of-range beat
//     ch_count   out  [NCH*16] per-channel handshake counts (stats build only)
//     err_count  out  [16] saturating addr_err pulse count (stats build only)
module demux_stream
  import demux_stream_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NCH    = 4,
  parameter int ADDR_W = addr_w_f(NCH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [NCH*WIDTH-1:0]   out_data,
  output logic [NCH-1:0]         out_valid,
  input  logic [NCH-1:0]         out_ready,
  output logic                   addr_err
`ifdef DEMUX_STREAM_STATS_EN
  ,
  output logic [NCH*STATS_W-1:0] ch_count,
  output logic [STATS_W-1:0]     err_count
`endif
);

  logic [NCH-1:0] w_sel;
  logic           w_in_range;
  logic           w_in_ready;
  logic           w_accept;
  logic [NCH-1:0] w_load;
  logic           r_addr_err;

  // Address decode and ready mux. An address that matches no channel is
  // always ready so that the producer never deadlocks on a bad address.
  always_comb begin
    w_sel      = '0;
    w_in_range = 1'b0;
    w_in_ready = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      if (in_addr == ADDR_W'(k)) begin
        w_sel[k]   = 1'b1;
        w_in_range = 1'b1;
        w_in_ready = !out_valid[k] || out_ready[k];
      end
    end
  end

  assign in_ready = w_in_ready;
  assign w_accept = in_valid && w_in_ready;
  assign w_load   = w_sel & {NCH{w_accept}};

  for (genvar g = 0; g < NCH; g++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[g]),
      .i_drain (out_ready[g]),
      .i_data  (in_data),
      .o_valid (out_valid[g]),
      .o_data  (out_data[g*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_accept && !w_in_range;
    end
  end

  assign addr_err = r_addr_err;

`ifdef DEMUX_STREAM_STATS_EN
  logic [STATS_W-1:0] r_ch_count [NCH];
  logic [STATS_W-1:0] r_err_count;

  // Channel counts wrap naturally; the error count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        r_ch_count[k] <= '0;
      end
      r_err_count <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          r_ch_count[k] <= r_ch_count[k] + 1'b1;
        end
      end
      if (r_addr_err && (r_err_count != {STATS_W{1'b1}})) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_cnt
    assign ch_count[g*STATS_W +: STATS_W] = r_ch_count[g];
  end
  assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_demux_stream.sv
module tb_demux_stream;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam int N3 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // NCH=4 instance
  logic [W-1:0]   in_data;
  logic [AW-1:0]  in_addr;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready;
  logic           addr_err;

  // NCH=3 instance (out-of-range address reachable)
  logic [W-1:0]    d3_data;
  logic [AW-1:0]   d3_addr;
  logic            d3_valid;
  logic            d3_in_ready;
  logic [N3*W-1:0] d3_out_data;
  logic [N3-1:0]   d3_out_valid;
  logic [N3-1:0]   d3_out_ready;
  logic            d3_addr_err;

`ifdef DEMUX_STREAM_STATS_EN
  logic [N*16-1:0]  ch_count;
  logic [15:0]      err_count;
  logic [N3*16-1:0] d3_ch_count;
  logic [15:0]      d3_err_count;
`endif

  demux_stream #(.WIDTH(W), .NCH(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .addr_err  (addr_err)
`ifdef DEMUX_STREAM_STATS_EN
    ,
    .ch_count  (ch_count),
    .err_count (err_count)
`endif
  );

  demux_stream #(.WIDTH(W), .NCH(N3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (d3_data),
    .in_addr   (d3_addr),
    .in_valid  (d3_valid),
    .in_ready  (d3_in_ready),
    .out_data  (d3_out_data),
    .out_valid (d3_out_valid),
    .out_ready (d3_out_ready),
    .addr_err  (d3_addr_err)
`ifdef DEMUX_STREAM_STATS_EN
    ,
    .ch_count  (d3_ch_count),
    .err_count (d3_err_count)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model of the NCH=4 instance: each channel is a one-deep
  // mailbox holding (present, value); value survives after delivery.
  bit          m_full [N];
  logic [W-1:0] m_val [N];
  int          m_delivered [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_full[k]      = 1'b0;
      m_val[k]       = '0;
      m_delivered[k] = 0;
    end
  endtask

  function automatic logic [N-1:0] model_valid();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = m_full[k];
    return v;
  endfunction

  function automatic logic [N*W-1:0] model_data();
    logic [N*W-1:0] d;
    for (int k = 0; k < N; k++) d[k*W +: W] = m_val[k];
    return d;
  endfunction

  // One clock of traffic: check in_ready before the edge, then outputs after.
  task automatic step(input string tag);
    int  a;
    bit  rdy;
    bit  take;
    #1;
    a    = int'(in_addr);
    rdy  = (a >= N) ? 1'b1 : (!m_full[a] || out_ready[a]);
    take = in_valid && rdy;
    check({tag, ".in_ready"}, in_ready, rdy);
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      if (m_full[k] && out_ready[k]) begin
        m_full[k] = 1'b0;
        m_delivered[k]++;
      end
    end
    if (take && a < N) begin
      m_full[a] = 1'b1;
      m_val[a]  = in_data;
    end
    #1;
    check({tag, ".out_valid"}, out_valid, model_valid());
    check({tag, ".out_data"}, out_data, model_data());
    check({tag, ".addr_err"}, addr_err, 1'b0);
`ifdef DEMUX_STREAM_STATS_EN
    for (int k = 0; k < N; k++) begin
      check({tag, ".ch_count"}, ch_count[k*16 +: 16], 16'(m_delivered[k]));
    end
    check({tag, ".err_count"}, err_count, 16'h0);
`endif
  endtask

  initial begin
    rst          = 1'b1;
    in_data      = '0;
    in_addr      = '0;
    in_valid     = 1'b0;
    out_ready    = '1;
    d3_data      = '0;
    d3_addr      = '0;
    d3_valid     = 1'b0;
    d3_out_ready = '1;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset.out_valid", out_valid, '0);
    check("reset.out_data", out_data, '0);
    check("reset.addr_err", addr_err, 1'b0);
    check("reset.d3_valid", d3_out_valid, '0);
    rst = 1'b0;

    // Single beat to channel 2, 1-cycle latency, drains next cycle
    in_data = 8'hA5; in_addr = 2; in_valid = 1'b1; out_ready = '1;
    step("t1.send");
    check("t1.valid_onehot", out_valid, 4'b0100);
    check("t1.data_ch2", out_data[23:16], 8'hA5);
    in_valid = 1'b0;
    step("t1.drain");
    check("t1.valid_clear", out_valid, 4'b0000);

    // Stalled channel 1 back-pressures the second beat
    out_ready = 4'b1101;
    in_data = 8'h11; in_addr = 1; in_valid = 1'b1;
    step("t2.first");
    in_data = 8'h22;
    step("t2.blocked0");
    check("t2.held", out_data[15:8], 8'h11);
    step("t2.blocked1");
    out_ready = 4'b1111;
    step("t2.release");
    check("t2.second", out_data[15:8], 8'h22);
    check("t2.second_vld", out_valid[1], 1'b1);
    in_valid = 1'b0;
    step("t2.idle");

    // Stall on channel 0 does not block channel 3
    out_ready = 4'b1110;
    in_data = 8'h77; in_addr = 0; in_valid = 1'b1;
    step("t3.fill0");
    in_data = 8'h33; in_addr = 3;
    step("t3.send3");
    check("t3.both_valid", {out_valid[3], out_valid[0]}, 2'b11);
    check("t3.data3", out_data[31:24], 8'h33);
    in_valid = 1'b0; out_ready = '1;
    step("t3.drain");

    // Drain and refill channel 2 in the same cycle
    out_ready = 4'b1011;
    in_data = 8'h55; in_addr = 2; in_valid = 1'b1;
    step("t4.fill");
    out_ready = 4'b1111;
    in_data = 8'h44;
    step("t4.refill");
    check("t4.vld2", out_valid[2], 1'b1);
    check("t4.data2", out_data[23:16], 8'h44);
    in_valid = 1'b0;
    step("t4.idle");

    // NCH=3 instance: out-of-range address accepted and dropped
    d3_out_ready = '0;
    d3_data = 8'h9C; d3_addr = 2; d3_valid = 1'b1;
    step("t5.idle0");
    check("t5.d3_fill", d3_out_valid, 3'b100);
    d3_addr = 3; d3_data = 8'hEE;
    #1;
    check("t5.d3_ready_oor", d3_in_ready, 1'b1);
    step("t5.idle1");
    check("t5.d3_err_hi", d3_addr_err, 1'b1);
    check("t5.d3_vld_kept", d3_out_valid, 3'b100);
    check("t5.d3_data_kept", d3_out_data[23:16], 8'h9C);
    d3_valid = 1'b0;
    d3_addr  = 2;
    #1;
    check("t5.d3_ready_full", d3_in_ready, 1'b0);
    step("t5.idle2");
    check("t5.d3_err_lo", d3_addr_err, 1'b0);
`ifdef DEMUX_STREAM_STATS_EN
    check("t5.d3_err_count", d3_err_count, 16'd1);
`endif
    d3_out_ready = '1;

    // Randomized traffic against the mailbox model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_addr   = AW'($urandom_range(0, N - 1));
      in_data   = W'($urandom);
      out_ready = N'($urandom);
      step("rand");
    end
    in_valid = 1'b0;

    // Fill all channels, then reset asynchronously mid-cycle
    out_ready = '0;
    for (int k = 0; k < N; k++) begin
      in_addr = AW'(k); in_data = W'(8'hC0 + k); in_valid = 1'b1;
      step("t6.fill");
    end
    in_valid = 1'b0;
    check("t6.all_full", out_valid, 4'b1111);
    #2;
    rst = 1'b1;
    #1;
    check("t6.async_valid", out_valid, '0);
    check("t6.async_data", out_data, '0);
    check("t6.async_err", addr_err, 1'b0);
`ifdef DEMUX_STREAM_STATS_EN
    check("t6.async_cnt", ch_count, '0);
`endif
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = '1;
    step("t6.after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
